// File: rtl/mar_fetch.sv
// mar_fetch: memory address register and instruction-fetch read engine.
//
// Captures the program counter's address from the shared bus on MAR_load and
// runs a single req/ack read to instruction memory. The returned word is held
// in a data register for the instruction register/decoder.
//
// Optional feature macro: MAR_TIMEOUT_EN. When it is defined, a request that
// sees no ack for TIMEOUT_CYCLES cycles is aborted and MAR_error is set. When
// it is undefined, a request waits for ack indefinitely and MAR_error is 0.
//
// Ports:
//   MAR_clock       in   clock; all state changes on the rising edge
//   MAR_reset_n     in   asynchronous active-low reset
//   MAR_bus_in      in   [ADDR_WIDTH] shared address bus (PC tri-state output)
//   MAR_load        in   capture MAR_bus_in and start a read (accepted in idle only)
//   MAR_busy        out  high while a read is in progress (any non-idle state)
//   MAR_mem_addr    out  [ADDR_WIDTH] registered address to memory
//   MAR_mem_req     out  read request, held until ack
//   MAR_mem_ack     in   memory ack; MAR_mem_rdata is valid in the same cycle
//   MAR_mem_rdata   in   [DATA_WIDTH] memory read data
//   MAR_data_out    out  [DATA_WIDTH] last successfully read word
//   MAR_data_valid  out  one-cycle pulse after MAR_data_out is updated
//   MAR_error       out  sticky timeout flag, cleared by the next accepted load
module mar_fetch #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                  MAR_clock,
  input  logic                  MAR_reset_n,
  input  logic [ADDR_WIDTH-1:0] MAR_bus_in,
  input  logic                  MAR_load,
  output logic                  MAR_busy,
  output logic [ADDR_WIDTH-1:0] MAR_mem_addr,
  output logic                  MAR_mem_req,
  input  logic                  MAR_mem_ack,
  input  logic [DATA_WIDTH-1:0] MAR_mem_rdata,
  output logic [DATA_WIDTH-1:0] MAR_data_out,
  output logic                  MAR_data_valid,
  output logic                  MAR_error
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2,
    StErr  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic load_accept;
  logic timeout_hit;

  assign load_accept = (state_q == StIdle) && MAR_load;

`ifdef MAR_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            error_q, error_d;

  // Abort on the last allowed request cycle only if ack is absent there too.
  assign timeout_hit = (state_q == StReq) && !MAR_mem_ack &&
                       (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d   = cnt_q;
    error_d = error_q;
    if (load_accept) begin
      cnt_d   = '0;
      error_d = 1'b0;
    end else if ((state_q == StReq) && !MAR_mem_ack) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (timeout_hit) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge MAR_clock or negedge MAR_reset_n) begin
    if (!MAR_reset_n) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign MAR_error = error_q;
`else
  // Timeout parameter has no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign MAR_error          = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge MAR_clock or negedge MAR_reset_n) begin
    if (!MAR_reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic. Ack is only looked at while requesting.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (MAR_load) begin
          state_d = StReq;
          addr_d  = MAR_bus_in;
        end
      end
      StReq: begin
        if (MAR_mem_ack) begin
          data_d  = MAR_mem_rdata;
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StErr;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the state register only, so reset drops them at once.
  always_comb begin
    MAR_busy       = (state_q != StIdle);
    MAR_mem_req    = (state_q == StReq);
    MAR_data_valid = (state_q == StDone);
  end

  assign MAR_mem_addr = addr_q;
  assign MAR_data_out = data_q;

endmodule
